// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: state encodings,
// framing byte constants and the baud divider helper.
package uart_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD     = 4'd1,
    S_LATCH  = 4'd2,
    S_START  = 4'd3,
    S_DATA   = 4'd4,
    S_PARITY = 4'd5,
    S_STOP   = 4'd6
  } tx_state_e;

  localparam logic [7:0] LINE_FEED    = 8'h0A;
  localparam logic [7:0] CARRIAGE_RET = 8'h0D;

  // Clocks per bit; integer truncation matches the 434 used at 50 MHz / 115200.
  function automatic int unsigned baud_div_f(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses tick_o on the last count.
// clr_i restarts the period so the start bit is aligned to the latched byte.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [15:0] TERM_CNT = 16'(BAUD_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = (cnt_q == TERM_CNT) && !clr_i;

  // Next count: restart on clear or at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || tick_o) begin
      cnt_d = 16'd0;
    end
  end

  // Period counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the sample FIFO (normal read mode) and serialises each byte onto txd:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line idle; issue rdreq when the FIFO reports data
//   S_RD     | rdreq pulse cycle; FIFO presents q on the next cycle
//   S_LATCH  | capture q and its parity, restart bit timer, drive start bit
//   S_START  | start bit (0) for one bit period
//   S_DATA   | data bits 0..7, one bit period each
//   S_PARITY | parity bit (only when PARITY_EN=1)
//   S_STOP   | stop level (1) for STOP_BITS bit periods, then tx_done
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned BAUD_DIV   = baud_div_f(CLK_FREQ, BAUD),
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        empty,
  input  logic [7:0]  q,
  output logic        rdreq,
  output logic        txd,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] byte_cnt,
  output logic [15:0] line_cnt
);

  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [2:0]  bit_idx_q;
  logic        stop_idx_q;
  logic        txd_q;
  logic        rdreq_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] line_cnt_q;

  logic        baud_clr;
  logic        baud_tick;

  assign baud_clr = (state_q == S_LATCH);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (baud_clr),
    .tick_o (baud_tick)
  );

  assign rdreq    = rdreq_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign byte_cnt = byte_cnt_q;
  assign line_cnt = line_cnt_q;

  // FIFO handshake, bit sequencing and counters; all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      rdreq_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= 16'd0;
      line_cnt_q <= 16'd0;
    end else begin
      rdreq_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            rdreq_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          shift_q  <= q;
          parity_q <= (^q) ^ PAR_ODD;
          txd_q    <= 1'b0;
          state_q  <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            bit_idx_q <= 3'd0;
            txd_q     <= shift_q[0];
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                txd_q   <= parity_q;
                state_q <= S_PARITY;
              end else begin
                txd_q      <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            txd_q      <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_idx_q == STOP_LAST) begin
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              byte_cnt_q <= byte_cnt_q + 16'd1;
              if (shift_q == LINE_FEED) begin
                line_cnt_q <= line_cnt_q + 16'd1;
              end
              state_q <= S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances at BAUD_DIV=4 (8N1, 8E2, 8O2), each
// fed by a small normal-mode FIFO model. Expected frames go into a scoreboard
// when bytes are pushed and are popped as frames are decoded from txd.
module tb_fifo_uart_tx;

  localparam int BD = 4;

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n0, rst_n12;

  logic [7:0] mem [3][64];
  int         wr_cnt [3];
  int         rd_cnt [3];
  logic [7:0] q_a [3];
  int         pulses [3];
  int         underflow;
  int         cyc;

  logic        e0, e1, e2;
  logic        rdreq0, rdreq1, rdreq2;
  logic        txd0, txd1, txd2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] bc0, bc1, bc2;
  logic [15:0] lc0, lc1, lc2;

  int         tests = 0;
  int         fails = 0;
  exp_t       sb[$];
  logic [15:0] exp_bc = 16'd0;
  logic [15:0] exp_lc = 16'd0;

  assign e0 = (wr_cnt[0] == rd_cnt[0]);
  assign e1 = (wr_cnt[1] == rd_cnt[1]);
  assign e2 = (wr_cnt[2] == rd_cnt[2]);

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(rst_n0), .empty(e0), .q(q_a[0]), .rdreq(rdreq0), .txd(txd0),
    .busy(busy0), .tx_done(done0), .byte_cnt(bc0), .line_cnt(lc0));

  fifo_uart_tx #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset_n(rst_n12), .empty(e1), .q(q_a[1]), .rdreq(rdreq1), .txd(txd1),
    .busy(busy1), .tx_done(done1), .byte_cnt(bc1), .line_cnt(lc1));

  fifo_uart_tx #(.CLK_FREQ(400), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(rst_n12), .empty(e2), .q(q_a[2]), .rdreq(rdreq2), .txd(txd2),
    .busy(busy2), .tx_done(done2), .byte_cnt(bc2), .line_cnt(lc2));

  function automatic logic rdreq_of(input int s);
    return (s == 0) ? rdreq0 : (s == 1) ? rdreq1 : rdreq2;
  endfunction
  function automatic logic txd_of(input int s);
    return (s == 0) ? txd0 : (s == 1) ? txd1 : txd2;
  endfunction
  function automatic logic done_of(input int s);
    return (s == 0) ? done0 : (s == 1) ? done1 : done2;
  endfunction
  function automatic bit pe_of(input int s);
    return s != 0;
  endfunction
  function automatic int ns_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction
  function automatic logic odd_of(input int s);
    return s == 2;
  endfunction

  // FIFO read side: q valid the cycle after rdreq.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 3; s++) begin
      if (rdreq_of(s)) begin
        if (wr_cnt[s] == rd_cnt[s]) underflow <= underflow + 1;
        q_a[s]    <= mem[s][rd_cnt[s] % 64];
        rd_cnt[s] <= rd_cnt[s] + 1;
      end
    end
  end

  // rdreq high-cycle counter; one count per byte means one-cycle pulses.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (rdreq_of(s)) pulses[s] <= pulses[s] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    exp_t e;
    mem[sel][wr_cnt[sel] % 64] = d;
    wr_cnt[sel] = wr_cnt[sel] + 1;
    e.sel = sel;
    e.d   = d;
    e.p   = (^d) ^ odd_of(sel);
    sb.push_back(e);
  endtask

  task automatic sample_bit(input int sel, output logic b, inout int bad);
    @(negedge clk);
    b = txd_of(sel);
    for (int k = 1; k < BD; k++) begin
      @(negedge clk);
      if (txd_of(sel) !== b) bad++;
    end
  endtask

  // Decode one frame; bad counts any level not held for the whole bit period.
  task automatic capture(input int sel, output logic [7:0] d, output logic p,
                         output int bad, output int st, output int dn, output logic dv);
    int   n;
    logic b;
    bad = 0; d = 8'h00; p = 1'b0; st = -1; dn = -1; dv = 1'b0; n = 0;
    @(negedge clk);
    while (txd_of(sel) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (txd_of(sel) !== 1'b0) begin
      bad = -1;
      return;
    end
    st = cyc;
    for (int k = 1; k < BD; k++) begin
      @(negedge clk);
      if (txd_of(sel) !== 1'b0) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      sample_bit(sel, b, bad);
      d[i] = b;
    end
    if (pe_of(sel)) sample_bit(sel, p, bad);
    for (int k = 0; k < ns_of(sel) * BD; k++) begin
      @(negedge clk);
      if (txd_of(sel) !== 1'b1) bad++;
    end
    @(negedge clk);
    dv = done_of(sel);
    dn = cyc;
  endtask

  task automatic frame(input int sel, input string tag, output int st, output int dn);
    logic [7:0] d;
    logic       p;
    int         bad;
    logic       dv;
    exp_t       e;
    capture(sel, d, p, bad, st, dn, dv);
    if (bad < 0) begin
      chk($sformatf("%s_start_timeout", tag), {31'd0, txd_of(sel)}, 32'd0);
      return;
    end
    chk($sformatf("%s_sb_nonempty", tag), {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk($sformatf("%s_sel", tag), sel, e.sel);
    chk($sformatf("%s_data", tag), {24'd0, d}, {24'd0, e.d});
    if (pe_of(sel)) chk($sformatf("%s_parity", tag), {31'd0, p}, {31'd0, e.p});
    chk($sformatf("%s_bit_timing", tag), bad, 0);
    chk($sformatf("%s_tx_done", tag), {31'd0, dv}, 32'd1);
    if (sel == 0) begin
      exp_bc = exp_bc + 16'd1;
      if (e.d == 8'h0A) exp_lc = exp_lc + 16'd1;
    end
  endtask

  initial begin
    int st, dn, k0, prev_dn, viol, n;
    rst_n0 = 1'b0;
    rst_n12 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd0}, 32'd1);
    chk("rst_rdreq", {31'd0, rdreq0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_tx_done", {31'd0, done0}, 32'd0);
    chk("rst_byte_cnt", {16'd0, bc0}, 32'd0);
    chk("rst_line_cnt", {16'd0, lc0}, 32'd0);
    rst_n0 = 1'b1;
    rst_n12 = 1'b1;

    // Idle with empty FIFOs.
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (rdreq0 || rdreq1 || rdreq2 || busy0 || busy1 || busy2 ||
          done0 || done1 || done2 || !txd0 || !txd1 || !txd2) viol++;
    end
    chk("idle_quiet", viol, 0);

    // Single byte 0x55.
    @(negedge clk);
    k0 = cyc;
    push(0, 8'h55);
    frame(0, "single", st, dn);
    chk("single_start_latency", st, k0 + 3);
    @(negedge clk);
    chk("single_done_width", {31'd0, done0}, 32'd0);
    chk("single_byte_cnt", {16'd0, bc0}, {16'd0, exp_bc});

    // Back-to-back poll-frame tail.
    @(negedge clk);
    push(0, 8'hA5);
    push(0, 8'h0D);
    push(0, 8'h0A);
    push(0, 8'hBB);
    prev_dn = 0;
    for (int i = 0; i < 4; i++) begin
      frame(0, $sformatf("b2b%0d", i), st, dn);
      if (i > 0) chk($sformatf("b2b%0d_gap", i), st - prev_dn, 3);
      prev_dn = dn;
    end
    repeat (20) @(negedge clk);
    chk("b2b_byte_cnt", {16'd0, bc0}, {16'd0, exp_bc});
    chk("b2b_line_cnt", {16'd0, lc0}, {16'd0, exp_lc});
    chk("b2b_rdreq_pulses", pulses[0], 5);
    chk("b2b_busy_idle", {31'd0, busy0}, 32'd0);

    // Parity and two stop bits: even then odd.
    @(negedge clk);
    push(1, 8'h07);
    frame(1, "even2", st, dn);
    chk("even2_byte_cnt", {16'd0, bc1}, 32'd1);
    @(negedge clk);
    push(2, 8'h07);
    frame(2, "odd2", st, dn);
    chk("odd2_byte_cnt", {16'd0, bc2}, 32'd1);

    // Reset during data bit 3 of 0x34, then 0x81 must follow cleanly.
    @(negedge clk);
    push(0, 8'h34);
    push(0, 8'h81);
    n = 0;
    while (txd0 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_start_seen", {31'd0, txd0}, 32'd0);
    repeat (17) @(negedge clk);
    chk("rst_mid_bit3", {31'd0, txd0}, 32'd0);
    rst_n0 = 1'b0;
    #1;
    chk("rst_mid_txd", {31'd0, txd0}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
    chk("rst_mid_byte_cnt", {16'd0, bc0}, 32'd0);
    chk("rst_mid_line_cnt", {16'd0, lc0}, 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    exp_bc = 16'd0;
    exp_lc = 16'd0;
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    k0 = cyc;
    frame(0, "post_rst", st, dn);
    chk("post_rst_latency", st, k0 + 3);
    chk("post_rst_byte_cnt", {16'd0, bc0}, {16'd0, exp_bc});

    // byte_cnt wrap.
    @(negedge clk);
    force dut0.byte_cnt_q = 16'hFFFF;
    #1;
    release dut0.byte_cnt_q;
    chk("wrap_preload", {16'd0, bc0}, 32'h0000FFFF);
    exp_bc = 16'hFFFF;
    push(0, 8'hC3);
    frame(0, "wrap", st, dn);
    chk("wrap_byte_cnt", {16'd0, bc0}, {16'd0, exp_bc});
    chk("wrap_line_cnt", {16'd0, lc0}, {16'd0, exp_lc});
    repeat (10) @(negedge clk);
    chk("total_rdreq_pulses", pulses[0], 8);
    chk("no_underflow", underflow, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
